data_mem_mmio: RTL
==================

// Module: data_mem_mmio
// PURPOSE
//  Data-side memory stage downstream of the single-cycle core; consumes its alu_out/write_data/mem_write, returns read_data.
//  Word-addressed data RAM plus a small memory-mapped I/O page: GPIO, free-running cycle counter, compare timer with IRQ.
//  Reads are combinational (core completes loads in one cycle); all state updates occur on the rising clock edge.
// PARAMETERS
//  ADDR_W   8   RAM word-address bits; DEPTH = 2**ADDR_W words of 32 bits
//  GPIO_W   16  width of gpio_out / gpio_in
// PORTS
//  clk         in   1       system clock, rising edge
//  reset       in   1       synchronous, active-high reset
//  mem_write   in   1       store strobe from core
//  addr        in   32      byte address (core alu_out)
//  write_data  in   32      store data
//  read_data   out  32      load data, combinational from addr
//  gpio_in     in   GPIO_W  asynchronous external inputs
//  gpio_out    out  GPIO_W  output register
//  timer_irq   out  1       level = STATUS.timer_flag
// BEHAVIOUR
//  Decode: addr[31]=0 -> RAM; addr[31]=1 -> MMIO, register = addr[4:2]; addr[30:5] ignored in MMIO.
//  RAM: index = addr[ADDR_W+1:2]; bits above ignored (aliasing wraps). Write at posedge when mem_write.
//   Read-during-write, same word: read_data shows old contents that cycle, new contents next cycle. Reset does not clear RAM.
//  Alignment: addr[1:0]!=0 -> no write of any kind, read_data=0, STATUS.misalign set next edge (both regions).
//  MMIO map (word offset):
//   0 GPIO_OUT  RW  [GPIO_W-1:0], upper bits read 0
//   1 GPIO_IN   RO  gpio_in via 2-flop synchroniser (2-cycle latency), upper bits 0
//   2 CYCLE     RO  32-bit, +1 every cycle, wraps FFFFFFFF->0; writes ignored
//   3 TMR_CMP   RW  compare value
//   4 TMR_CTRL  RW  bit0 EN, bit1 AUTO_RELOAD; other bits read 0
//   5 TMR_CNT   RW  timer count
//   6 STATUS    W1C bit0 timer_flag, bit1 misalign; other bits read 0
//   7 reserved: reads 0, writes ignored
//  Timer, per edge with EN=1:
//   TMR_CNT==TMR_CMP -> timer_flag<=1; AUTO_RELOAD ? TMR_CNT<=0 : (EN<=0, TMR_CNT holds)
//   otherwise TMR_CNT<=TMR_CNT+1 (wraps 32-bit). EN=0 -> TMR_CNT holds.
//  Priority, same edge: software write to TMR_CNT/TMR_CTRL beats timer update; hardware set of a STATUS flag beats W1C clear.
//  Reset values: gpio_out=0, CYCLE=0, TMR_CMP=FFFFFFFF, TMR_CTRL=0, TMR_CNT=0, STATUS=0, synchroniser flops=0, timer_irq=0.
//   CYCLE reads 0 in the first cycle after reset release. Reset asserted mid-count returns all registers to reset values at that edge.
//  read_data is purely combinational: no latency; any addr change reflects in the same cycle.
// TESTING
//  1 Store 0xDEADBEEF @0x10, load @0x10 next cycle -> 0xDEADBEEF; load @(0x10 + 4*2**ADDR_W) -> same value (alias).
//  2 Store @0x12 (misaligned) -> RAM word 0x10 unchanged, read_data=0, timer_irq=0, STATUS=0x2; write 0x2 to STATUS -> 0.
//  3 CMP=3, CTRL=0x3 -> flag sets on 4th enabled edge, CNT 0,1,2,3,0,1...; timer_irq stays 1 until W1C.
//  4 CMP=2, CTRL=0x1 -> flag set, EN clears, CNT holds at 2; W1C on the edge the flag sets -> flag stays 1.
//  5 gpio_in=0xA5A5 -> GPIO_IN reads 0xA5A5 exactly 2 edges later; write 0x1234 to GPIO_OUT -> gpio_out=0x1234 next cycle.
//  6 Assert reset after 100 cycles with timer running -> all regs at reset values, CYCLE restarts at 0, RAM contents retained.

Source files
------------

// File: rtl/data_mem_mmio.sv
// rtl/data_mem_mmio.sv - data RAM plus MMIO page (GPIO, cycle counter, compare timer)
module data_mem_mmio #(
   parameter int ADDR_W = 8,
   parameter int GPIO_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_write,
   input  logic [31:0]       addr,
   input  logic [31:0]       write_data,
   output logic [31:0]       read_data,
   input  logic [GPIO_W-1:0] gpio_in,
   output logic [GPIO_W-1:0] gpio_out,
   output logic              timer_irq
);

   localparam int DEPTH = 2**ADDR_W;

   localparam logic [2:0] REG_GPIO_OUT = 3'd0;
   localparam logic [2:0] REG_GPIO_IN  = 3'd1;
   localparam logic [2:0] REG_CYCLE    = 3'd2;
   localparam logic [2:0] REG_TMR_CMP  = 3'd3;
   localparam logic [2:0] REG_TMR_CTRL = 3'd4;
   localparam logic [2:0] REG_TMR_CNT  = 3'd5;
   localparam logic [2:0] REG_STATUS   = 3'd6;

   logic [31:0]       r_ram [DEPTH];
   logic [GPIO_W-1:0] r_gpio_out;
   logic [GPIO_W-1:0] r_sync1;
   logic [GPIO_W-1:0] r_sync2;
   logic [31:0]       r_cycle;
   logic [31:0]       r_cmp;
   logic              r_en;
   logic              r_auto;
   logic [31:0]       r_cnt;
   logic              r_flag;
   logic              r_mis;

   logic              w_misalign;
   logic              w_mmio;
   logic [2:0]        w_reg;
   logic [ADDR_W-1:0] w_idx;
   logic              w_ram_we;
   logic              w_mmio_we;
   logic              w_clr_flag;
   logic              w_clr_mis;
   logic              w_mis_set;
   logic              w_fire;
   logic [31:0]       w_cnt_next;
   logic              w_en_next;
   logic              w_auto_next;
   logic              w_unused;

   // Address bits between the RAM index and the region select only alias.
   assign w_unused   = ^addr[30:ADDR_W+2];

   assign w_misalign = (addr[1:0] != 2'b00);
   assign w_mmio     = addr[31];
   assign w_reg      = addr[4:2];
   assign w_idx      = addr[ADDR_W+1:2];
   assign w_ram_we   = mem_write && !w_mmio && !w_misalign;
   assign w_mmio_we  = mem_write && w_mmio && !w_misalign;
   assign w_mis_set  = mem_write && w_misalign;
   assign w_clr_flag = w_mmio_we && (w_reg == REG_STATUS) && write_data[0];
   assign w_clr_mis  = w_mmio_we && (w_reg == REG_STATUS) && write_data[1];

   assign gpio_out   = r_gpio_out;
   assign timer_irq  = r_flag;

   // Combinational load path: RAM word or decoded MMIO register, zero when misaligned.
   always_comb begin
      read_data = 32'd0;
      if (!w_misalign) begin
         if (!w_mmio) begin
            read_data = r_ram[w_idx];
         end else begin
            case (w_reg)
               REG_GPIO_OUT: read_data = {{(32-GPIO_W){1'b0}}, r_gpio_out};
               REG_GPIO_IN:  read_data = {{(32-GPIO_W){1'b0}}, r_sync2};
               REG_CYCLE:    read_data = r_cycle;
               REG_TMR_CMP:  read_data = r_cmp;
               REG_TMR_CTRL: read_data = {30'd0, r_auto, r_en};
               REG_TMR_CNT:  read_data = r_cnt;
               REG_STATUS:   read_data = {30'd0, r_mis, r_flag};
               default:      read_data = 32'd0;
            endcase
         end
      end
   end

   // Timer next state; a software write to CNT or CTRL overrides the hardware update.
   always_comb begin
      w_fire      = r_en && (r_cnt == r_cmp);
      w_cnt_next  = r_cnt;
      w_en_next   = r_en;
      w_auto_next = r_auto;
      if (r_en) begin
         if (w_fire) begin
            if (r_auto) begin
               w_cnt_next = 32'd0;
            end else begin
               w_en_next = 1'b0;
            end
         end else begin
            w_cnt_next = r_cnt + 32'd1;
         end
      end
      if (w_mmio_we && (w_reg == REG_TMR_CNT)) begin
         w_cnt_next = write_data;
      end
      if (w_mmio_we && (w_reg == REG_TMR_CTRL)) begin
         w_en_next   = write_data[0];
         w_auto_next = write_data[1];
      end
   end

   // RAM store port; contents survive reset.
   always_ff @(posedge clk) begin
      if (w_ram_we) begin
         r_ram[w_idx] <= write_data;
      end
   end

   // MMIO register file, synchroniser, cycle counter and timer state.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_gpio_out <= '0;
         r_sync1    <= '0;
         r_sync2    <= '0;
         r_cycle    <= 32'd0;
         r_cmp      <= 32'hFFFF_FFFF;
         r_en       <= 1'b0;
         r_auto     <= 1'b0;
         r_cnt      <= 32'd0;
         r_flag     <= 1'b0;
         r_mis      <= 1'b0;
      end else begin
         r_sync1 <= gpio_in;
         r_sync2 <= r_sync1;
         r_cycle <= r_cycle + 32'd1;
         if (w_mmio_we && (w_reg == REG_GPIO_OUT)) begin
            r_gpio_out <= write_data[GPIO_W-1:0];
         end
         if (w_mmio_we && (w_reg == REG_TMR_CMP)) begin
            r_cmp <= write_data;
         end
         r_cnt  <= w_cnt_next;
         r_en   <= w_en_next;
         r_auto <= w_auto_next;
         // Hardware set wins over a simultaneous write-one-to-clear.
         r_flag <= w_fire || (r_flag && !w_clr_flag);
         r_mis  <= w_mis_set || (r_mis && !w_clr_mis);
      end
   end

endmodule
